demux_1_4_stream: RTL

DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_1_4_stream_if.sv | 29 ++
 rtl/lane_fifo2.sv | 59 +++++
 rtl/demux_1_4_stream.sv | 57 +++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
//   N_LANES    : number of output lanes
//   lane_idx_t : lane index type carried on in_sel
//   lane_onehot: lane index -> one-hot lane mask
package demux_pkg;

  localparam int unsigned N_LANES = 4;

  typedef logic [1:0] lane_idx_t;

  function automatic logic [N_LANES-1:0] lane_onehot(input lane_idx_t idx);
    logic [N_LANES-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_4_stream_if.sv
// Stream bus between a single-word source and four lane sinks.
//   in_valid/in_ready/in_data/in_sel : input handshake, word and destination lane
//   out_valid/out_ready/out_data     : per-lane handshake, lane i word on [i*W +: W]
// master: source/sink side (drives inputs, observes outputs)
// slave : demultiplexer side
interface demux_1_4_stream_if #(
  parameter int unsigned W = 4
) ();
  import demux_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  lane_idx_t            in_sel;
  logic [N_LANES-1:0]   out_valid;
  logic [N_LANES-1:0]   out_ready;
  logic [N_LANES*W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lane_fifo2.sv
// Two-entry FIFO for one lane, no routing knowledge.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and word; ignored while full
//   pop        : read request; ignored while empty
//   full/empty : occupancy flags
//   dout       : oldest entry, all-zero while empty
module lane_fifo2 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    full    = (count == 2'd2);
    empty   = (count == 2'd0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    dout    = empty ? '0 : mem[rd_ptr];
  end

  // Single-bit pointers wrap modulo 2 by toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demultiplexer with a 2-entry FIFO per lane.
//   clk   : sole clock
//   rst_n : asynchronous active-low reset, empties all lanes
//   bus   : stream bus (slave side), see demux_1_4_stream_if
// in_ready reflects only the selected lane's full flag (gated by reset), so a
// full lane never stalls traffic bound for another lane, and a full lane stays
// unavailable even when it pops in the same cycle.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demux_1_4_stream_if.slave        bus
);

  logic [N_LANES-1:0]   full;
  logic [N_LANES-1:0]   empty;
  logic [N_LANES-1:0]   push;
  logic [W-1:0]         head [N_LANES];
  logic                 ready;
  logic [N_LANES-1:0]   valid_vec;
  logic [N_LANES*W-1:0] data_vec;

  always_comb begin
    ready = rst_n & ~full[bus.in_sel];
    push  = (bus.in_valid && ready) ? lane_onehot(bus.in_sel) : '0;
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_fifo2 #(.W(W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (bus.out_ready[g]),
      .din   (bus.in_data),
      .full  (full[g]),
      .empty (empty[g]),
      .dout  (head[g])
    );
  end

  always_comb begin
    valid_vec = '0;
    data_vec  = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      valid_vec[i]       = ~empty[i];
      data_vec[i*W +: W] = head[i];
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_vec;
  assign bus.out_data  = data_vec;

endmodule
